// File: rtl/config_register_bank.sv
// AXI4-Lite configuration/status register bank for the up-sampling accelerator.
// Holds control, interrupt enable/status and per-channel saturating stream handshake counters.
module config_register_bank #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_CH         = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [1:0]                  s_axi_bresp,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                  s_axi_arprot,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    input  logic                        ac_crf_wrt,
    input  logic [AXI_ADDR_WIDTH-1:0]   ac_crf_waddr,
    input  logic [AXI_DATA_WIDTH-1:0]   ac_crf_wdata,
    output logic                        crf_ac_wbusy,
    output logic                        crf_ac_UPSTART,
    output logic                        crf_ac_UPEND,
    output logic                        interrupt_updone,
    input  logic [NUM_CH-1:0]           ac_crf_tvalid,
    input  logic [NUM_CH-1:0]           ac_crf_tready,
    input  logic                        ac_crf_processing
);
    localparam int NB = AXI_DATA_WIDTH / 8;
    localparam int IW = AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {WIDLE, WGOTA, WGOTD, WCOMMIT, WRESP} wstate_e;
    typedef enum logic {RIDLE, RDATA} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;

    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]             wstrb_q, wstrb_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [AXI_DATA_WIDTH-1:0] upstat_q, upstat_d;
    logic                      irqen_q, irqen_d;
    logic                      irqstat_q, irqstat_d;
    logic                      upend_prev_q, upend_prev_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] hsk_q, hsk_d, nrdy_q, nrdy_d;

    logic aw_hs, w_hs;
    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;

    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = aw_hs ? s_axi_awaddr : awaddr_q;
        wdata_d  = w_hs ? s_axi_wdata : wdata_q;
        wstrb_d  = w_hs ? s_axi_wstrb : wstrb_q;
        case (wstate_q)
            WIDLE: begin
                if (aw_hs && w_hs) wstate_d = WCOMMIT;
                else if (aw_hs)    wstate_d = WGOTA;
                else if (w_hs)     wstate_d = WGOTD;
            end
            WGOTA:   if (w_hs) wstate_d = WCOMMIT;
            WGOTD:   if (aw_hs) wstate_d = WCOMMIT;
            WCOMMIT: wstate_d = WRESP;
            WRESP:   if (s_axi_bready) wstate_d = WIDLE;
            default: wstate_d = WIDLE;
        endcase
    end

    // A single write source per cycle: the AXI commit owns the bank, the PL port is refused.
    logic                      wr_en;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]             wr_strb;
    logic [IW-1:0]             wr_idx;
    logic                      wr_ok;
    logic                      irq_clr;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = awaddr_q;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
        if (wstate_q == WCOMMIT) begin
            wr_en = 1'b1;
        end else if (ac_crf_wrt) begin
            wr_en   = 1'b1;
            wr_addr = ac_crf_waddr;
            wr_data = ac_crf_wdata;
            wr_strb = '1;
        end
    end

    assign wr_idx = wr_addr[AXI_ADDR_WIDTH-1:2];
    assign wr_ok  = wr_idx < IW'(3);

    always_comb begin
        upstat_d = upstat_q;
        irqen_d  = irqen_q;
        irq_clr  = 1'b0;
        bresp_d  = bresp_q;
        if (wr_en) begin
            case (wr_idx)
                IW'(0): for (int b = 0; b < NB; b++)
                            if (wr_strb[b]) upstat_d[8*b +: 8] = wr_data[8*b +: 8];
                IW'(1): if (wr_strb[0]) irqen_d = wr_data[0];
                IW'(2): irq_clr = wr_data[0] & wr_strb[0];
                default: ;
            endcase
        end
        if (wstate_q == WCOMMIT) bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
        // Set has priority over a simultaneous W1C clear.
        upend_prev_d = upstat_q[1];
        irqstat_d    = irqstat_q;
        if (upstat_q[1] && !upend_prev_q) irqstat_d = 1'b1;
        else if (irq_clr)                 irqstat_d = 1'b0;
    end

    always_comb begin
        hsk_d  = hsk_q;
        nrdy_d = nrdy_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (upstat_q[0] && ac_crf_processing) begin
                if (ac_crf_tvalid[k] && ac_crf_tready[k] && hsk_q[k] != '1)
                    hsk_d[k] = hsk_q[k] + CNT_WIDTH'(1);
                if (ac_crf_tvalid[k] && !ac_crf_tready[k] && nrdy_q[k] != '1)
                    nrdy_d[k] = nrdy_q[k] + CNT_WIDTH'(1);
            end else if (!(!ac_crf_processing && upstat_q[1])) begin
                hsk_d[k]  = '0;
                nrdy_d[k] = '0;
            end
        end
    end

    logic [IW-1:0]             rd_idx;
    logic [AXI_DATA_WIDTH-1:0] rd_val;
    logic                      rd_ok;
    assign rd_idx = s_axi_araddr[AXI_ADDR_WIDTH-1:2];

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b1;
        if (rd_idx == IW'(0)) begin
            rd_val = upstat_q;
        end else if (rd_idx == IW'(1)) begin
            rd_val[0] = irqen_q;
        end else if (rd_idx == IW'(2)) begin
            rd_val[0] = irqstat_q;
        end else begin
            rd_ok = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (rd_idx == IW'(4 + 2*k)) begin
                    rd_val = AXI_DATA_WIDTH'(hsk_q[k]);
                    rd_ok  = 1'b1;
                end
                if (rd_idx == IW'(5 + 2*k)) begin
                    rd_val = AXI_DATA_WIDTH'(nrdy_q[k]);
                    rd_ok  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            RIDLE: if (s_axi_arvalid) begin
                rstate_d = RDATA;
                rdata_d  = rd_val;
                rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            RDATA:   if (s_axi_rready) rstate_d = RIDLE;
            default: rstate_d = RIDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q     <= WIDLE;
            rstate_q     <= RIDLE;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bresp_q      <= '0;
            rresp_q      <= '0;
            rdata_q      <= '0;
            upstat_q     <= '0;
            irqen_q      <= 1'b0;
            irqstat_q    <= 1'b0;
            upend_prev_q <= 1'b0;
            hsk_q        <= '0;
            nrdy_q       <= '0;
        end else begin
            wstate_q     <= wstate_d;
            rstate_q     <= rstate_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bresp_q      <= bresp_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            upstat_q     <= upstat_d;
            irqen_q      <= irqen_d;
            irqstat_q    <= irqstat_d;
            upend_prev_q <= upend_prev_d;
            hsk_q        <= hsk_d;
            nrdy_q       <= nrdy_d;
        end
    end

    assign s_axi_awready    = (wstate_q == WIDLE) || (wstate_q == WGOTD);
    assign s_axi_wready     = (wstate_q == WIDLE) || (wstate_q == WGOTA);
    assign s_axi_bvalid     = (wstate_q == WRESP);
    assign s_axi_bresp      = bresp_q;
    assign s_axi_arready    = (rstate_q == RIDLE);
    assign s_axi_rvalid     = (rstate_q == RDATA);
    assign s_axi_rdata      = rdata_q;
    assign s_axi_rresp      = rresp_q;
    assign crf_ac_wbusy     = (wstate_q == WCOMMIT);
    assign crf_ac_UPSTART   = upstat_q[0];
    assign crf_ac_UPEND     = upstat_q[1];
    assign interrupt_updone = irqstat_q & irqen_q;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0]};
endmodule
